// File: rtl/raif_rw_sched.sv
// Read/write scheduler: maps the RAIF read and write ports onto one DRAM command port.
// It keeps one direction for up to MAX_SAME bursts, completes zero-length requests locally, and has a watchdog.
module raif_rw_sched #(
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_ADDR_WIDTH = 28,
  parameter int MAX_SAME       = 4,
  parameter int TIMEOUT        = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rd_req,
  input  logic [APP_ADDR_WIDTH-1:0]   rd_addr,
  input  logic [9:0]                  rd_num,
  output logic [APP_DATA_WIDTH-1:0]   rd_data,
  output logic                        rd_grant,
  output logic                        rd_finish,
  input  logic                        wr_req,
  input  logic [APP_ADDR_WIDTH-1:0]   wr_addr,
  input  logic [9:0]                  wr_num,
  input  logic [APP_DATA_WIDTH-1:0]   wr_data,
  input  logic [APP_DATA_WIDTH/8-1:0] wr_mask,
  output logic                        wr_grant,
  output logic                        wr_finish,
  output logic                        cmd_req,
  output logic                        cmd_we,
  output logic [APP_ADDR_WIDTH-1:0]   cmd_addr,
  output logic [9:0]                  cmd_num,
  input  logic                        cmd_grant,
  input  logic                        cmd_finish,
  input  logic [APP_DATA_WIDTH-1:0]   mem_rd_data,
  output logic [APP_DATA_WIDTH-1:0]   mem_wr_data,
  output logic [APP_DATA_WIDTH/8-1:0] mem_wr_mask,
  output logic                        busy,
  output logic                        err_timeout
);
  localparam int CNT_W = $clog2(MAX_SAME + 1);
  localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] SAME_MAX = CNT_W'(MAX_SAME);
  localparam logic [WD_W-1:0]  WD_LAST  = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
  localparam bit               WD_EN    = (TIMEOUT > 0);

  typedef enum logic [1:0] {IDLE, REQ, BUSY, ZLEN} state_t;

  state_t                    state;
  logic                      zlen_fin;
  logic                      last_dir;   // 1 = write
  logic [CNT_W-1:0]          same_cnt;
  logic [WD_W-1:0]           wd_cnt;

  logic                      pick_we;
  logic [APP_ADDR_WIDTH-1:0] pick_addr;
  logic [9:0]                pick_num;
  logic                      wd_expire;
  logic                      grant_evt;
  logic                      finish_evt;

  always_comb begin
    pick_we = last_dir;
    if (rd_req && !wr_req)       pick_we = 1'b0;
    else if (wr_req && !rd_req)  pick_we = 1'b1;
    else if (same_cnt < SAME_MAX) pick_we = last_dir;
    else                         pick_we = ~last_dir;
    pick_addr = pick_we ? wr_addr : rd_addr;
    pick_num  = pick_we ? wr_num  : rd_num;

    wd_expire  = WD_EN && (state == BUSY) && !cmd_finish && (wd_cnt == WD_LAST);
    grant_evt  = ((state == REQ) && cmd_grant) || ((state == ZLEN) && !zlen_fin);
    finish_evt = ((state == REQ) && cmd_grant && cmd_finish) ||
                 ((state == BUSY) && (cmd_finish || wd_expire)) ||
                 ((state == ZLEN) && zlen_fin);
  end

  // Handshake pulses are combinational so they line up with cmd_grant/cmd_finish.
  assign rd_grant    = grant_evt  & ~cmd_we;
  assign wr_grant    = grant_evt  &  cmd_we;
  assign rd_finish   = finish_evt & ~cmd_we;
  assign wr_finish   = finish_evt &  cmd_we;
  assign busy        = (state != IDLE);
  assign rd_data     = mem_rd_data;
  assign mem_wr_data = wr_data;
  assign mem_wr_mask = wr_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      zlen_fin    <= 1'b0;
      cmd_req     <= 1'b0;
      cmd_we      <= 1'b0;
      cmd_addr    <= '0;
      cmd_num     <= '0;
      err_timeout <= 1'b0;
      last_dir    <= 1'b0;
      same_cnt    <= '0;
      wd_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_req || wr_req) begin
            cmd_we   <= pick_we;
            cmd_addr <= pick_addr;
            cmd_num  <= pick_num;
            last_dir <= pick_we;
            if (pick_we == last_dir)
              same_cnt <= (same_cnt >= SAME_MAX) ? SAME_MAX : same_cnt + CNT_W'(1);
            else
              same_cnt <= CNT_W'(1);
            if (pick_num == 10'd0) begin
              state    <= ZLEN;
              zlen_fin <= 1'b0;
            end else begin
              state   <= REQ;
              cmd_req <= 1'b1;
            end
          end
        end
        REQ: begin
          if (cmd_grant) begin
            cmd_req <= 1'b0;
            wd_cnt  <= '0;
            state   <= cmd_finish ? IDLE : BUSY;
          end
        end
        BUSY: begin
          if (finish_evt) begin
            state <= IDLE;
            if (wd_expire) err_timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        ZLEN: begin
          if (zlen_fin) state <= IDLE;
          else          zlen_fin <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_raif_rw_sched.sv
// Bench for raif_rw_sched: directed vector table, watchdog/reset sequences and random transactions.
// A transaction-level arbitration model supplies the expected direction for the random part.
module tb_raif_rw_sched;
  localparam int DW = 128;
  localparam int AW = 28;
  localparam int MAX_SAME = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0, rst = 1'b1;
  logic rd_req = 0, wr_req = 0, cmd_grant = 0, cmd_finish = 0;
  logic [AW-1:0] rd_addr = '0, wr_addr = '0, cmd_addr;
  logic [9:0] rd_num = '0, wr_num = '0, cmd_num;
  logic [DW-1:0] rd_data, wr_data = '0, mem_rd_data = '0, mem_wr_data;
  logic [DW/8-1:0] wr_mask = '0, mem_wr_mask;
  logic rd_grant, rd_finish, wr_grant, wr_finish, cmd_req, cmd_we, busy, err_timeout;

  int checks = 0, errors = 0, txn_no = 0;
  bit m_last = 0;
  int m_cnt = 0;

  raif_rw_sched #(.APP_DATA_WIDTH(DW), .APP_ADDR_WIDTH(AW), .MAX_SAME(MAX_SAME), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_num(rd_num), .rd_data(rd_data),
    .rd_grant(rd_grant), .rd_finish(rd_finish),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_num(wr_num), .wr_data(wr_data), .wr_mask(wr_mask),
    .wr_grant(wr_grant), .wr_finish(wr_finish),
    .cmd_req(cmd_req), .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_num(cmd_num),
    .cmd_grant(cmd_grant), .cmd_finish(cmd_finish),
    .mem_rd_data(mem_rd_data), .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rq, wq;
    logic [AW-1:0] ra, wa;
    logic [9:0] rn, wn;
    int gd, fd;
    bit both;
    bit exp_we;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arbitration rule applied to whole requests: returns the direction served and advances the model.
  task automatic model_pick(input bit rq, input bit wq, output bit we);
    if (rq && !wq)      we = 1'b0;
    else if (wq && !rq) we = 1'b1;
    else                we = (m_cnt < MAX_SAME) ? m_last : !m_last;
    if (we == m_last) m_cnt = (m_cnt + 1 > MAX_SAME) ? MAX_SAME : m_cnt + 1;
    else              m_cnt = 1;
    m_last = we;
  endtask

  // Drives one request set from an IDLE cycle, plays the controller, checks every cycle; ends in IDLE.
  task automatic run_txn(input bit rq, input bit wq, input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                         input logic [9:0] rn, input logic [9:0] wn, input int gd, input int fd,
                         input bit both, input bit exp_we);
    logic [9:0] en;
    logic [AW-1:0] ea;
    en = exp_we ? wn : rn;
    ea = exp_we ? wa : ra;
    rd_req = rq; wr_req = wq; rd_addr = ra; wr_addr = wa; rd_num = rn; wr_num = wn;
    wr_data = {$urandom, $urandom, $urandom, $urandom};
    mem_rd_data = {$urandom, $urandom, $urandom, $urandom};
    wr_mask = {$urandom(), $urandom()} & 16'hffff;
    #1;
    chk("idle_busy", busy, 0);
    chk("rd_data_pass", rd_data, mem_rd_data);
    chk("wr_data_pass", mem_wr_data, wr_data);
    chk("wr_mask_pass", mem_wr_mask, wr_mask);
    tick();
    chk("cmd_we", cmd_we, exp_we);
    chk("cmd_addr", cmd_addr, ea);
    chk("cmd_num", cmd_num, en);
    chk("busy_after_pick", busy, 1);
    if (en == 0) begin
      chk("zlen_no_cmd", cmd_req, 0);
      chk("zlen_rd_grant", rd_grant, !exp_we);
      chk("zlen_wr_grant", wr_grant, exp_we);
      chk("zlen_early_fin", rd_finish | wr_finish, 0);
      tick();
      chk("zlen_no_cmd2", cmd_req, 0);
      chk("zlen_busy2", busy, 1);
      chk("zlen_grant_once", rd_grant | wr_grant, 0);
      chk("zlen_rd_finish", rd_finish, !exp_we);
      chk("zlen_wr_finish", wr_finish, exp_we);
      tick();
      chk("zlen_done", busy, 0);
    end else begin
      chk("cmd_req_rise", cmd_req, 1);
      for (int i = 0; i < gd; i++) begin
        chk("early_grant", rd_grant | wr_grant, 0);
        tick();
        chk("cmd_req_hold", cmd_req, 1);
      end
      cmd_grant = 1; cmd_finish = both;
      #1;
      chk("rd_grant", rd_grant, !exp_we);
      chk("wr_grant", wr_grant, exp_we);
      chk("rd_finish_at_grant", rd_finish, both && !exp_we);
      chk("wr_finish_at_grant", wr_finish, both && exp_we);
      tick();
      cmd_grant = 0; cmd_finish = 0;
      #1;
      chk("cmd_req_drop", cmd_req, 0);
      chk("grant_once", rd_grant | wr_grant, 0);
      if (both) begin
        chk("same_cycle_idle", busy, 0);
      end else begin
        for (int i = 0; i < fd; i++) begin
          chk("early_finish", rd_finish | wr_finish, 0);
          chk("busy_wait", busy, 1);
          tick();
        end
        cmd_finish = 1;
        #1;
        chk("rd_finish", rd_finish, !exp_we);
        chk("wr_finish", wr_finish, exp_we);
        tick();
        cmd_finish = 0;
        #1;
        chk("done_idle", busy, 0);
      end
    end
    $display("txn %0d dir=%s addr=%0h num=%0d gd=%0d fd=%0d same=%0b", txn_no, exp_we ? "W" : "R",
             ea, en, gd, fd, both);
    txn_no++;
  endtask

  vec_t vecs[13];
  bit we, rp, wp;
  logic [AW-1:0] ra, wa;
  logic [9:0] rn, wn;

  initial begin
    // both ports held from reset: R x4, W x4, R; then zero-length, same-cycle and plain read cases
    for (int i = 0; i < 9; i++)
      vecs[i] = '{1, 1, AW'(28'h200 + i), AW'(28'h800 + i), 10'd4, 10'd2, 1, 2, 0,
                  (i >= 4 && i < 8)};
    vecs[9]  = '{0, 1, 28'h0, 28'h0a0, 10'd0, 10'd0, 0, 0, 0, 1};
    vecs[10] = '{1, 0, 28'h3c0, 28'h0, 10'd6, 10'd0, 1, 0, 1, 0};
    vecs[11] = '{1, 0, 28'h100, 28'h0, 10'd8, 10'd0, 3, 10, 0, 0};
    vecs[12] = '{1, 0, 28'h040, 28'h0, 10'd0, 10'd0, 0, 0, 0, 0};

    repeat (3) tick();
    chk("rst_cmd_req", cmd_req, 0);
    chk("rst_cmd_we", cmd_we, 0);
    chk("rst_cmd_addr", cmd_addr, 0);
    chk("rst_cmd_num", cmd_num, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_pulses", {rd_grant, rd_finish, wr_grant, wr_finish}, 0);
    rst = 0;

    foreach (vecs[i]) begin
      model_pick(vecs[i].rq, vecs[i].wq, we);
      run_txn(vecs[i].rq, vecs[i].wq, vecs[i].ra, vecs[i].wa, vecs[i].rn, vecs[i].wn,
              vecs[i].gd, vecs[i].fd, vecs[i].both, vecs[i].exp_we);
    end
    rd_req = 0; wr_req = 0;

    // Watchdog: write granted, never finished
    model_pick(0, 1, we);
    wr_req = 1; wr_addr = 28'habc; wr_num = 10'd5;
    tick();
    chk("wd_cmd_req", cmd_req, 1);
    chk("wd_cmd_we", cmd_we, 1);
    cmd_grant = 1;
    #1;
    chk("wd_wr_grant", wr_grant, 1);
    tick();
    cmd_grant = 0; wr_req = 0;
    for (int i = 1; i < TIMEOUT; i++) begin
      chk("wd_early_finish", wr_finish, 0);
      chk("wd_early_err", err_timeout, 0);
      tick();
    end
    chk("wd_wr_finish", wr_finish, 1);
    chk("wd_rd_finish", rd_finish, 0);
    chk("wd_err_not_yet", err_timeout, 0);
    tick();
    chk("wd_err_set", err_timeout, 1);
    chk("wd_idle", busy, 0);
    $display("txn %0d dir=W watchdog expiry", txn_no);
    txn_no++;
    model_pick(1, 0, we);
    run_txn(1, 0, 28'h555, 28'h0, 10'd3, 10'd0, 1, 4, 0, we);
    rd_req = 0;
    chk("wd_err_sticky", err_timeout, 1);

    // Reset during BUSY of a write
    wr_req = 1; wr_addr = 28'h777; wr_num = 10'd9;
    tick();
    cmd_grant = 1;
    tick();
    cmd_grant = 0; wr_req = 0;
    tick();
    chk("pre_rst_busy", busy, 1);
    rst = 1;
    #1;
    chk("mid_rst_cmd_req", cmd_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err_timeout, 0);
    tick();
    rst = 0;
    m_last = 0; m_cnt = 0;
    $display("txn %0d dir=W reset mid-transaction", txn_no);
    txn_no++;
    model_pick(0, 1, we);
    run_txn(0, 1, 28'h0, 28'h123, 10'd0, 10'd7, 0, 2, 0, we);
    model_pick(1, 1, we);
    run_txn(1, 1, 28'h321, 28'h124, 10'd5, 10'd7, 1, 1, 0, we);
    chk("post_rst_dir", cmd_we, 1);

    // Random traffic: losing requests stay pending with the same parameters
    rp = 0; wp = 0; ra = '0; wa = '0; rn = '0; wn = '0;
    for (int t = 0; t < 150; t++) begin
      if (!rp && ($urandom % 3 != 0)) begin
        rp = 1; ra = AW'($urandom);
        rn = ($urandom % 6 == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      end
      if (!wp && ($urandom % 3 != 0)) begin
        wp = 1; wa = AW'($urandom);
        wn = ($urandom % 6 == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      end
      if (!rp && !wp) begin
        rp = 1; ra = AW'($urandom); rn = 10'($urandom_range(1, 1023));
      end
      model_pick(rp, wp, we);
      run_txn(rp, wp, ra, wa, rn, wn, $urandom_range(0, 4), $urandom_range(0, 10),
              ($urandom % 5 == 0), we);
      if (we) wp = 0; else rp = 0;
    end
    rd_req = 0; wr_req = 0;
    tick();
    chk("final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end
endmodule

// File: doc/raif_rw_sched.md
Name: raif_rw_sched

Overview:
- Schedules the RAIF read port and the RAIF write port onto one single-command DRAM backend that executes one transaction at a time, read or write.
- Sits between raif_arb's downstream RAIF ports and the DRAM controller command port.
- Keeps the current direction for up to MAX_SAME consecutive bursts to cut bus turnarounds, then switches when the other direction is waiting.
- Completes zero-length requests locally and flags hung transactions with a watchdog.

Parameters:
APP_DATA_WIDTH, 128, data width of rd/wr data
APP_ADDR_WIDTH, 28, address width
MAX_SAME, 4, max consecutive same-direction bursts while the other direction is pending (>=1)
TIMEOUT, 4096, cycles allowed from cmd grant to cmd_finish; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
rd_req  in  1  RAIF read request; held high until rd_grant
rd_addr  in  APP_ADDR_WIDTH  read start address
rd_num  in  10  read beat count
rd_data  out  APP_DATA_WIDTH  read data, combinational from mem_rd_data
rd_grant  out  1  one-cycle read accept pulse
rd_finish  out  1  one-cycle read completion pulse
wr_req  in  1  RAIF write request; held high until wr_grant
wr_addr  in  APP_ADDR_WIDTH  write start address
wr_num  in  10  write beat count
wr_data  in  APP_DATA_WIDTH  write data
wr_mask  in  APP_DATA_WIDTH/8  write byte mask
wr_grant  out  1  one-cycle write accept pulse
wr_finish  out  1  one-cycle write completion pulse
cmd_req  out  1  command request to DRAM controller (registered)
cmd_we  out  1  1 = write, 0 = read (registered)
cmd_addr  out  APP_ADDR_WIDTH  latched address
cmd_num  out  10  latched beat count
cmd_grant  in  1  controller accept pulse
cmd_finish  in  1  controller completion pulse
mem_rd_data  in  APP_DATA_WIDTH  read data from controller
mem_wr_data  out  APP_DATA_WIDTH  combinational from wr_data
mem_wr_mask  out  APP_DATA_WIDTH/8  combinational from wr_mask
busy  out  1  state != IDLE
err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (async, rst=1): state=IDLE; cmd_req=0, cmd_we=0, cmd_addr=0, cmd_num=0, err_timeout=0; last_dir=READ; same_cnt=0; wd_cnt=0. All grant/finish outputs are 0 and busy=0.
- FSM states: IDLE, REQ, BUSY, ZLEN.
- IDLE:
  - Direction pick:
    - only one req high -> that direction.
    - both high and same_cnt<MAX_SAME -> last_dir.
    - both high and same_cnt>=MAX_SAME -> opposite of last_dir.
  - Latch addr/num/dir into cmd_*.
  - Update counter: same dir as last_dir -> same_cnt=min(same_cnt+1,MAX_SAME); otherwise same_cnt=1. last_dir=dir.
  - Next state: num==0 -> ZLEN; else -> REQ with cmd_req=1 on the next cycle. Decision-to-cmd_req latency is 1 cycle.
- REQ:
  - cmd_req held high until cmd_grant.
  - On cmd_grant: the selected rd_grant/wr_grant pulses in that same cycle (combinational); cmd_req drops next cycle; -> BUSY.
  - cmd_grant and cmd_finish in the same cycle: grant and finish pulse together; -> IDLE.
- BUSY:
  - On cmd_finish: selected rd_finish/wr_finish pulses in that same cycle (combinational); -> IDLE. A new decision is possible on the following cycle.
- ZLEN:
  - Cycle 1: grant pulse. Cycle 2: finish pulse. -> IDLE.
  - No downstream command; last_dir and same_cnt are still updated.
- Watchdog (TIMEOUT>0):
  - wd_cnt clears on entry to BUSY and increments each BUSY cycle.
  - wd_cnt==TIMEOUT-1 without cmd_finish: err_timeout=1 (sticky until rst), finish pulse to the requester, -> IDLE.
  - wd_cnt is not active in REQ.
- Data paths:
  - rd_data = mem_rd_data; mem_wr_data = wr_data; mem_wr_mask = wr_mask (combinational, all states).
  - Beat timing is owned by the controller.
- Grant/finish outputs are gated by state and cmd_we. A cmd_grant outside REQ, or a cmd_finish outside REQ/BUSY, is ignored.
- Requester deasserting req before grant is illegal. The block completes the latched transaction regardless.
- Reset mid-transaction: immediate return to IDLE and cmd_req=0. The controller must be reset together with this block.

Test Plan:
- Read only, rd_addr=0x100, rd_num=8. Controller grants 3 cycles after cmd_req and finishes 10 cycles later -> cmd_we=0, cmd_addr=0x100, cmd_num=8; rd_grant and rd_finish each pulse once, aligned with cmd_grant/cmd_finish; wr_* outputs stay 0.
- rd_req and wr_req held continuously, MAX_SAME=4, out of reset -> command sequence R,R,R,R,W,W,W,W,R… Each grant is a single pulse.
- wr_num=0 with the controller idle -> no cmd_req; wr_grant pulses, then wr_finish on the next cycle; busy high for 2 cycles.
- Controller asserts cmd_grant and cmd_finish in the same cycle for a read -> rd_grant and rd_finish both pulse that cycle; state is IDLE the next cycle.
- TIMEOUT=16, controller grants a write and never finishes -> err_timeout rises after the 16th BUSY cycle with wr_finish pulsed in the same cycle; a subsequent rd_req is then served normally.
- Assert rst during BUSY of a write -> cmd_req, busy and err_timeout read 0 immediately; after rst release a wr_req is re-issued cleanly with same_cnt restarting (direction = write, same_cnt=1).
